// File: rtl/exec_sequencer_pkg.sv
// Shared encodings for the multi-cycle execution sequencer:
// PC select codes, mcause values, FSM states and decoder flag bundle.
package exec_sequencer_pkg;

    localparam logic [1:0] PC_SEL_INC  = 2'd0;
    localparam logic [1:0] PC_SEL_ALU  = 2'd1;
    localparam logic [1:0] PC_SEL_TRAP = 2'd2;
    localparam logic [1:0] PC_SEL_MEPC = 2'd3;

    localparam logic [3:0] MCAUSE_ILLEGAL     = 4'd2;
    localparam logic [3:0] MCAUSE_BREAKPOINT  = 4'd3;
    localparam logic [3:0] MCAUSE_LOAD_FAULT  = 4'd5;
    localparam logic [3:0] MCAUSE_STORE_FAULT = 4'd7;
    localparam logic [3:0] MCAUSE_ECALL_M     = 4'd11;

    typedef enum logic [1:0] {
        S_EXEC0    = 2'd0,
        S_EXEC1    = 2'd1,
        S_LSU_WAIT = 2'd2,
        S_MM_WAIT  = 2'd3
    } seq_state_e;

    typedef enum logic [3:0] {
        OP_PLAIN,
        OP_BRANCH,
        OP_JUMP,
        OP_MM,
        OP_LSU,
        OP_MRET,
        OP_EBREAK,
        OP_ECALL,
        OP_ILLEGAL
    } op_e;

    typedef struct packed {
        logic jump;
        logic branch;
        logic lsu_r;
        logic lsu_w;
        logic mm;
        logic ecall;
        logic ebreak;
        logic mret;
        logic illegal;
    } dec_flags_t;

    // Collapse decoder flags into one class, highest priority first.
    function automatic op_e classify(input dec_flags_t f);
        op_e op;
        if (f.illegal)                op = OP_ILLEGAL;
        else if (f.ecall)             op = OP_ECALL;
        else if (f.ebreak)            op = OP_EBREAK;
        else if (f.mret)              op = OP_MRET;
        else if (f.lsu_r || f.lsu_w)  op = OP_LSU;
        else if (f.mm)                op = OP_MM;
        else if (f.jump)              op = OP_JUMP;
        else if (f.branch)            op = OP_BRANCH;
        else                          op = OP_PLAIN;
        return op;
    endfunction

endpackage

// File: rtl/exec_sequencer_lsu_watchdog.sv
// Saturating clear/enable counter flagging an LSU request held too long.
// Ports: clk_i, rst_ni, clr_i (zero), en_i (count), timeout_o (limit hit).
module lsu_watchdog #(
    parameter int unsigned LSU_TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);
    import exec_sequencer_pkg::*;

    localparam int unsigned CW =
        (LSU_TIMEOUT > 0) ? $clog2(LSU_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(LSU_TIMEOUT);
    localparam logic [CW-1:0] SAT   = {CW{1'b1}};

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != SAT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero limit disables the watchdog entirely.
    assign timeout_o = (LSU_TIMEOUT != 0) && (cnt_q >= LIMIT);

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle execution controller: sequences retire, jumps, branches,
// LSU and matrix-unit waits and traps. Outputs are Mealy, forced to 0 in reset.
module exec_sequencer #(
    parameter int unsigned LSU_TIMEOUT = 255
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       instr_valid_i,
    input  logic       rf_we_i,
    input  logic       jump_inst_i,
    input  logic       branch_inst_i,
    input  logic       lsu_r_en_i,
    input  logic       lsu_w_en_i,
    input  logic       mm_start_i,
    input  logic       ecall_inst_i,
    input  logic       ebreak_inst_i,
    input  logic       mret_inst_i,
    input  logic       illegal_inst_i,
    input  logic       branch_taken_i,
    input  logic       lsu_done_i,
    input  logic       mm_done_i,
    output logic       cycle_counter_o,
    output logic       instr_ack_o,
    output logic       pc_we_o,
    output logic [1:0] pc_sel_o,
    output logic       rf_we_o,
    output logic       lsu_req_o,
    output logic       mm_req_o,
    output logic       trap_o,
    output logic [3:0] trap_cause_o,
    output logic       busy_o
);
    import exec_sequencer_pkg::*;

    seq_state_e state_q, state_d;
    dec_flags_t flags;
    op_e        op;

    logic       cc_c;
    logic       ack_c;
    logic [1:0] sel_c;
    logic       rf_we_c;
    logic       lsu_req_c;
    logic       mm_req_c;
    logic       trap_c;
    logic [3:0] cause_c;
    logic       wd_en;
    logic       wd_timeout;

    assign flags = '{
        jump:    jump_inst_i,
        branch:  branch_inst_i,
        lsu_r:   lsu_r_en_i,
        lsu_w:   lsu_w_en_i,
        mm:      mm_start_i,
        ecall:   ecall_inst_i,
        ebreak:  ebreak_inst_i,
        mret:    mret_inst_i,
        illegal: illegal_inst_i
    };
    assign op = classify(flags);

    always_comb begin
        state_d   = state_q;
        cc_c      = 1'b0;
        ack_c     = 1'b0;
        sel_c     = PC_SEL_INC;
        rf_we_c   = 1'b0;
        lsu_req_c = 1'b0;
        mm_req_c  = 1'b0;
        trap_c    = 1'b0;
        cause_c   = 4'd0;

        case (state_q)
            S_EXEC0: begin
                if (instr_valid_i) begin
                    case (op)
                        OP_ILLEGAL: begin
                            trap_c  = 1'b1;
                            cause_c = MCAUSE_ILLEGAL;
                        end
                        OP_ECALL: begin
                            trap_c  = 1'b1;
                            cause_c = MCAUSE_ECALL_M;
                        end
                        OP_EBREAK: begin
                            trap_c  = 1'b1;
                            cause_c = MCAUSE_BREAKPOINT;
                        end
                        OP_MRET: begin
                            ack_c = 1'b1;
                            sel_c = PC_SEL_MEPC;
                        end
                        OP_LSU: begin
                            lsu_req_c = 1'b1;
                            if (lsu_done_i) begin
                                ack_c   = 1'b1;
                                rf_we_c = rf_we_i;
                            end else begin
                                state_d = S_LSU_WAIT;
                            end
                        end
                        OP_MM: begin
                            mm_req_c = 1'b1;
                            state_d  = S_EXEC1;
                        end
                        OP_JUMP: begin
                            // Link register written now, target next cycle.
                            rf_we_c = 1'b1;
                            state_d = S_EXEC1;
                        end
                        OP_BRANCH: begin
                            if (branch_taken_i) begin
                                state_d = S_EXEC1;
                            end else begin
                                ack_c = 1'b1;
                            end
                        end
                        default: begin
                            ack_c   = 1'b1;
                            rf_we_c = rf_we_i;
                        end
                    endcase
                end
            end
            S_EXEC1: begin
                cc_c = 1'b1;
                if (op == OP_MM) begin
                    // mm_done_i is deliberately ignored here.
                    mm_req_c = 1'b1;
                    state_d  = S_MM_WAIT;
                end else begin
                    ack_c   = 1'b1;
                    sel_c   = PC_SEL_ALU;
                    state_d = S_EXEC0;
                end
            end
            S_LSU_WAIT: begin
                if (lsu_done_i) begin
                    lsu_req_c = 1'b1;
                    ack_c     = 1'b1;
                    rf_we_c   = rf_we_i;
                    state_d   = S_EXEC0;
                end else if (wd_timeout) begin
                    trap_c  = 1'b1;
                    cause_c = lsu_w_en_i ? MCAUSE_STORE_FAULT
                                         : MCAUSE_LOAD_FAULT;
                end else begin
                    lsu_req_c = 1'b1;
                end
            end
            S_MM_WAIT: begin
                cc_c = 1'b1;
                if (mm_done_i) begin
                    ack_c   = 1'b1;
                    rf_we_c = rf_we_i;
                    state_d = S_EXEC0;
                end
            end
            default: state_d = S_EXEC0;
        endcase

        // Traps override every enable and redirect to the handler.
        if (trap_c) begin
            ack_c     = 1'b1;
            sel_c     = PC_SEL_TRAP;
            rf_we_c   = 1'b0;
            lsu_req_c = 1'b0;
            mm_req_c  = 1'b0;
            state_d   = S_EXEC0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_EXEC0;
        end else begin
            state_q <= state_d;
        end
    end

    // Count only cycles where a request stays pending; anything else zeroes.
    assign wd_en = lsu_req_c & ~lsu_done_i;

    lsu_watchdog #(
        .LSU_TIMEOUT(LSU_TIMEOUT)
    ) u_wdog (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (~wd_en),
        .en_i     (wd_en),
        .timeout_o(wd_timeout)
    );

    // Reset forces every output low even with live decoder inputs.
    assign cycle_counter_o = rst_ni & cc_c;
    assign instr_ack_o     = rst_ni & ack_c;
    assign pc_we_o         = rst_ni & ack_c;
    assign pc_sel_o        = rst_ni ? sel_c : PC_SEL_INC;
    assign rf_we_o         = rst_ni & rf_we_c;
    assign lsu_req_o       = rst_ni & lsu_req_c;
    assign mm_req_o        = rst_ni & mm_req_c;
    assign trap_o          = rst_ni & trap_c;
    assign trap_cause_o    = rst_ni ? cause_c : 4'd0;
    assign busy_o          = rst_ni & (state_q != S_EXEC0);

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
Multi-cycle execution controller for the single-issue RV32I core. It sits between fetch, the instruction decoder and the execute datapath, and drives the decoder's cycle_counter_i. It gates register-file, LSU and matrix-unit (CUSTOM0) enables, and selects the next PC. It also sequences traps for ecall, ebreak, illegal instructions and LSU timeout.

Parameters:
LSU_TIMEOUT, 255, max cycles lsu_req_o may stay high without lsu_done_i before an access-fault trap; 0 disables the watchdog.

Ports:
clk_i  in  1  core clock
rst_ni  in  1  asynchronous active-low reset
instr_valid_i  in  1  fetch presents a valid instruction; held stable until instr_ack_o
rf_we_i  in  1  decoder rf_we_o
jump_inst_i  in  1  decoder JAL/JALR flag
branch_inst_i  in  1  decoder branch flag
lsu_r_en_i  in  1  decoder load flag
lsu_w_en_i  in  1  decoder store flag
mm_start_i  in  1  decoder CUSTOM0 flag
ecall_inst_i  in  1  decoder ecall flag
ebreak_inst_i  in  1  decoder ebreak flag
mret_inst_i  in  1  decoder mret flag
illegal_inst_i  in  1  decoder illegal flag
branch_taken_i  in  1  ALU compare result bit 0
lsu_done_i  in  1  LSU access complete (data valid for loads)
mm_done_i  in  1  matrix unit complete
cycle_counter_o  out  1  to decoder cycle_counter_i
instr_ack_o  out  1  instruction retired/trapped; fetch advances
pc_we_o  out  1  PC register write enable
pc_sel_o  out  2  PC_SEL_INC=0, PC_SEL_ALU=1, PC_SEL_TRAP=2, PC_SEL_MEPC=3
rf_we_o  out  1  gated register-file write enable
lsu_req_o  out  1  LSU request, level, held until done
mm_req_o  out  1  matrix unit operand-valid
trap_o  out  1  one-cycle trap pulse to CSR unit (also writes mepc)
trap_cause_o  out  4  mcause code, valid with trap_o
busy_o  out  1  state is not S_EXEC0

Behaviour:
- States: S_EXEC0, S_EXEC1, S_LSU_WAIT, S_MM_WAIT. The state and watchdog counter are registered. All outputs are combinational from state and inputs (Mealy).
- Reset (asynchronous, rst_ni=0): state becomes S_EXEC0 and the counter is cleared.
- During reset all outputs are 0; pc_sel_o is PC_SEL_INC and trap_cause_o is 0.
- cycle_counter_o=1 only in S_EXEC1 and S_MM_WAIT.
- S_EXEC0 with instr_valid_i=0: all enables are 0 and the state holds.
- Decode in S_EXEC0 uses this priority: illegal > ecall > ebreak > mret > load/store > mm > jump > branch > plain.
- Illegal/ecall/ebreak: trap_o=1, trap_cause_o = 2, 11 or 3 respectively. Also pc_we_o=1, pc_sel_o=TRAP, instr_ack_o=1, rf_we_o=0, and the LSU and mm requests are suppressed.
- mret: pc_we_o=1, pc_sel_o=MEPC, instr_ack_o=1.
- Plain instruction (ALU/LUI/AUIPC/CSR): rf_we_o=rf_we_i, pc_we_o=1, pc_sel_o=INC, instr_ack_o=1. Retires in 1 cycle.
- Jump:
  - S_EXEC0: rf_we_o=1 (link write), no PC write, go to S_EXEC1.
  - S_EXEC1: pc_we_o=1, pc_sel_o=ALU, instr_ack_o=1, go to S_EXEC0.
  - Retires in 2 cycles.
- Branch:
  - S_EXEC0 with branch_taken_i=0: retires with PC_SEL_INC in 1 cycle.
  - S_EXEC0 with branch_taken_i=1: go to S_EXEC1, which writes the PC with PC_SEL_ALU and acks. Retires in 2 cycles.
- Load/store:
  - lsu_req_o=1 in S_EXEC0.
  - If lsu_done_i=1 in the same cycle, retire immediately. rf_we_o=rf_we_i is asserted only in the done cycle.
  - Otherwise go to S_LSU_WAIT, hold lsu_req_o, and increment the counter each cycle.
  - On lsu_done_i: retire and go to S_EXEC0.
  - If the counter reaches LSU_TIMEOUT with no done: trap with cause 5 (load) or 7 (store), lsu_req_o=0 in that cycle, rf_we_o=0.
  - lsu_done_i wins over the timeout in the same cycle.
- CUSTOM0:
  - S_EXEC0: mm_req_o=1, go to S_EXEC1.
  - S_EXEC1: mm_req_o=1, go to S_MM_WAIT.
  - S_MM_WAIT: cycle_counter_o=1, retire on mm_done_i.
  - mm_done_i arriving in S_EXEC1 is ignored; only S_MM_WAIT samples it.
- instr_ack_o and pc_we_o are asserted together, exactly once per instruction.
- Reset mid-operation aborts the instruction. Requests drop asynchronously and no ack or trap is issued.
- The watchdog counter is width $clog2(LSU_TIMEOUT+1) and saturates.

Decomposition:
- PC_SEL_* encodings, sequencer state encodings and MCAUSE_* constants (2, 3, 5, 7, 11) go in riscv_defines.v.
- One sub-module, lsu_watchdog: clear/enable counter with a timeout flag, bypassed when LSU_TIMEOUT=0.

Test Plan:
- ADDI with instr_valid_i=1 -> rf_we_o=1, pc_we_o=1, pc_sel_o=0 and instr_ack_o in cycle 0; busy_o=0 throughout.
- JAL -> cycle 0: rf_we_o=1, pc_we_o=0, cycle_counter_o=0. Cycle 1: cycle_counter_o=1, pc_sel_o=1, ack.
- BEQ with branch_taken_i=0 -> ack in cycle 0 with pc_sel_o=0. BEQ with branch_taken_i=1 -> ack in cycle 1 with pc_sel_o=1.
- Load with lsu_done_i after 3 cycles -> lsu_req_o high for 4 cycles and rf_we_o=1 only in the 4th, then ack. With LSU_TIMEOUT=4 and no done -> trap_o=1, cause 5, pc_sel_o=2.
- Illegal asserted with lsu_r_en_i=1 -> trap cause 2, lsu_req_o never high. Ecall -> cause 11.
- CUSTOM0 with mm_done_i after 5 cycles -> mm_req_o high for 2 cycles, cycle_counter_o=1 from cycle 1, ack on done. rst_ni low mid-wait -> all outputs 0, state S_EXEC0.
